tube_dma_ctrl: RTL
==================

Name: tube_dma_ctrl

Overview:
- Parasite-side DMA sequencer for the Tube ULA register-3 DMA channel.
- Services DRQ by issuing DACK-qualified read/write strobes to the ULA.
- Moves each byte to or from parasite memory over a simple req/ack memory port.
- Programmed with start address, byte count and direction; raises a done interrupt at terminal count.

Parameters:
- AW, 16, memory address width
- CW, 16, byte-count width

Ports:
- HO2  in  1  system clock; all state changes on rising edge
- HRST  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; begin transfer (honoured only in IDLE)
- DIR  in  1  0 = host->parasite (ULA read, memory write); 1 = parasite->host (memory read, ULA write)
- SADDR  in  AW  start memory address
- SCNT  in  CW  byte count
- IRQ_CLR  in  1  clears IRQ
- DRQ  in  1  ULA DMA request, active high
- DACK  out  1  ULA DMA acknowledge, active low
- PNRDS  out  1  ULA read strobe, active low
- PNWDS  out  1  ULA write strobe, active low
- PDIN  out  8  data to ULA
- PDOUT  in  8  data from ULA
- MREQ  out  1  memory request
- MWE  out  1  memory write enable (valid with MREQ)
- MADDR  out  AW  memory address
- MWDATA  out  8  memory write data
- MRDATA  in  8  memory read data, valid with MACK
- MACK  in  1  memory acknowledge; one-cycle pulse completes access
- BUSY  out  1  high from START acceptance until DONE state exits
- DONE  out  1  one-cycle pulse at transfer end
- IRQ  out  1  sticky done interrupt
- REMAIN  out  CW  bytes still to move

Behaviour:
- Reset values:
  - DACK=PNRDS=PNWDS=1.
  - MREQ=MWE=BUSY=DONE=IRQ=0.
  - PDIN=MWDATA=MADDR=REMAIN=0.
  - State IDLE.
- Reset is effective mid-transfer: the transfer is abandoned, no strobe is completed, and REMAIN is lost.
- IDLE:
  - START with SCNT!=0 latches SADDR->MADDR, SCNT->REMAIN, DIR, sets BUSY, then goes to WAIT_DRQ.
  - START with SCNT==0 goes directly to DONE; no bus cycles are issued.
- WAIT_DRQ: on DRQ=1, go to ULA_RD if DIR=0, or MEM_RD if DIR=1.
- ULA_RD:
  - Exactly one cycle with DACK=0 and PNRDS=0.
  - PDOUT is captured into MWDATA at the closing edge.
  - Next state MEM_WR.
- MEM_WR:
  - MREQ=1, MWE=1, held stable until the cycle MACK=1.
  - On that edge go to ADV.
- MEM_RD:
  - MREQ=1, MWE=0, held until MACK=1.
  - MRDATA is captured into PDIN; next state ULA_WR.
- ULA_WR:
  - Exactly one cycle with DACK=0 and PNWDS=0; PDIN is stable throughout.
  - Next state ADV.
- ADV (one cycle):
  - MADDR+1, wrapping modulo 2^AW (0xFFFF->0x0000); REMAIN-1.
  - If REMAIN was 1, go to DONE; otherwise go to SETTLE.
- SETTLE: one idle cycle so a stale DRQ is never resampled; then WAIT_DRQ.
- DONE:
  - DONE=1 for one cycle, IRQ set, BUSY cleared on exit, back to IDLE.
- IRQ:
  - Stays high until IRQ_CLR.
  - If IRQ_CLR and a new set coincide, set wins.
- Strobe and request rules:
  - START while BUSY is ignored.
  - DRQ is ignored outside WAIT_DRQ.
  - DACK, PNRDS and PNWDS are never low simultaneously with MREQ.
  - PNRDS and PNWDS are mutually exclusive.
- Minimum byte period (zero-wait memory, DRQ already high): 5 cycles.

Optional Feature:
- Macro TUBE_DMA_ABORT_EN adds input ABORT (active-high pulse).
- ABORT in WAIT_DRQ, SETTLE or ADV goes to DONE without raising IRQ; REMAIN holds the untransferred count.
- ABORT during a ULA strobe cycle or a memory access is deferred until that byte's ADV completes.
- Without the macro there is no ABORT port, and transfers always run to terminal count.

Test Plan:
- Reset check: HRST low mid-MEM_WR -> all outputs at reset values within the same cycle, state IDLE after release.
- Host->parasite transfer:
  - Setup: DIR=0, SADDR=0x1000, SCNT=3, PDOUT=0xAA,0xAB,0xAC on three DRQ assertions.
  - Required: three one-cycle PNRDS/DACK pulses; memory writes 0x1000=0xAA, 0x1001=0xAB, 0x1002=0xAC; one DONE pulse; IRQ=1; REMAIN=0.
- Parasite->host transfer:
  - Setup: DIR=1, SCNT=2, memory returns 0x55,0x56 with MACK after 2 wait cycles.
  - Required: PNWDS pulses carry PDIN=0x55 then 0x56; no strobe before MACK.
- Zero count and busy: SCNT=0 -> DONE within 2 cycles, no DACK/MREQ activity; second START while BUSY -> no effect on REMAIN.
- Wrap: SADDR=0xFFFF, SCNT=2 -> addresses 0xFFFF then 0x0000.
- DRQ held high continuously: exactly SCNT strobes, each separated by a SETTLE cycle; IRQ_CLR and DONE in the same cycle -> IRQ=1.

Source files
------------

// File: rtl/tube_dma_ctrl.sv
// Tube ULA register-3 DMA sequencer: moves bytes between the ULA and parasite memory.
// Optional: define TUBE_DMA_ABORT_EN to add the ABORT input.
module tube_dma_ctrl #(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic          HO2,
    input  logic          HRST,
    input  logic          START,
    input  logic          DIR,
    input  logic [AW-1:0] SADDR,
    input  logic [CW-1:0] SCNT,
    input  logic          IRQ_CLR,
`ifdef TUBE_DMA_ABORT_EN
    input  logic          ABORT,
`endif
    input  logic          DRQ,
    output logic          DACK,
    output logic          PNRDS,
    output logic          PNWDS,
    output logic [7:0]    PDIN,
    input  logic [7:0]    PDOUT,
    output logic          MREQ,
    output logic          MWE,
    output logic [AW-1:0] MADDR,
    output logic [7:0]    MWDATA,
    input  logic [7:0]    MRDATA,
    input  logic          MACK,
    output logic          BUSY,
    output logic          DONE,
    output logic          IRQ,
    output logic [CW-1:0] REMAIN
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_DRQ,
        S_ULA_RD,
        S_MEM_WR,
        S_MEM_RD,
        S_ULA_WR,
        S_ADV,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_dir;
    logic [AW-1:0] r_maddr;
    logic [CW-1:0] r_remain;
    logic [7:0]    r_mwdata;
    logic [7:0]    r_pdin;
    logic          r_irq;
    logic          r_aborted;
    logic          w_abort;
    logic          w_abort_take;
    logic          w_irq_set;

`ifdef TUBE_DMA_ABORT_EN
    logic r_abort_pend;
    logic w_in_byte;

    // An abort raised mid-byte is parked until that byte's ADV cycle.
    assign w_in_byte = (r_state == S_ULA_RD) || (r_state == S_MEM_WR) ||
                       (r_state == S_MEM_RD) || (r_state == S_ULA_WR);
    assign w_abort   = ABORT | r_abort_pend;

    always_ff @(posedge HO2 or negedge HRST) begin
        if (!HRST) begin
            r_abort_pend <= 1'b0;
        end else begin
            r_abort_pend <= w_in_byte & (r_abort_pend | ABORT);
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge HO2 or negedge HRST) begin
        if (!HRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_abort_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (SCNT != '0) ? S_WAIT_DRQ : S_DONE;
                end
            end
            S_WAIT_DRQ: begin
                if (w_abort) begin
                    w_next       = S_DONE;
                    w_abort_take = 1'b1;
                end else if (DRQ) begin
                    w_next = r_dir ? S_MEM_RD : S_ULA_RD;
                end
            end
            S_ULA_RD: w_next = S_MEM_WR;
            S_MEM_WR: if (MACK) w_next = S_ADV;
            S_MEM_RD: if (MACK) w_next = S_ULA_WR;
            S_ULA_WR: w_next = S_ADV;
            S_ADV: begin
                if (r_remain == CW'(1)) begin
                    w_next = S_DONE;
                end else if (w_abort) begin
                    w_next       = S_DONE;
                    w_abort_take = 1'b1;
                end else begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_abort) begin
                    w_next       = S_DONE;
                    w_abort_take = 1'b1;
                end else begin
                    w_next = S_WAIT_DRQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Terminal-count completion raises IRQ; an abort-ended transfer does not.
    assign w_irq_set = (r_state == S_DONE) && !r_aborted;

    always_ff @(posedge HO2 or negedge HRST) begin
        if (!HRST) begin
            r_dir     <= 1'b0;
            r_maddr   <= '0;
            r_remain  <= '0;
            r_mwdata  <= '0;
            r_pdin    <= '0;
            r_irq     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (r_state != S_DONE) begin
                r_aborted <= w_abort_take;
            end
            r_irq <= w_irq_set | (r_irq & ~IRQ_CLR);
            case (r_state)
                S_IDLE: begin
                    if (START && (SCNT != '0)) begin
                        r_maddr  <= SADDR;
                        r_remain <= SCNT;
                        r_dir    <= DIR;
                    end
                end
                S_ULA_RD: r_mwdata <= PDOUT;
                S_MEM_RD: if (MACK) r_pdin <= MRDATA;
                S_ADV: begin
                    r_maddr  <= r_maddr + AW'(1);
                    r_remain <= r_remain - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign DACK   = !((r_state == S_ULA_RD) || (r_state == S_ULA_WR));
    assign PNRDS  = (r_state != S_ULA_RD);
    assign PNWDS  = (r_state != S_ULA_WR);
    assign MREQ   = (r_state == S_MEM_WR) || (r_state == S_MEM_RD);
    assign MWE    = (r_state == S_MEM_WR);
    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = (r_state == S_DONE);
    assign IRQ    = r_irq;
    assign PDIN   = r_pdin;
    assign MWDATA = r_mwdata;
    assign MADDR  = r_maddr;
    assign REMAIN = r_remain;

endmodule
